// File: rtl/rv32_data_bus_bridge_pkg.sv
// Shared types and constants for the core-to-bus data bridge.
package rv32_data_bus_bridge_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam logic [3:0]  FULL_STROBE        = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ_REQ,
        READ_WAIT,
        DONE
    } bridge_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } store_entry_t;

    // The bus only ever sees word addresses; byte lanes are selected by strobes.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_data_bus_bridge_store_fifo.sv
// Posted-store FIFO: power-of-two depth, pointers wrap modulo depth,
// full is taken from the count at the start of the cycle (no bypass).
module rv32_store_fifo
    import rv32_data_bus_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  store_entry_t             push_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output store_entry_t             head
);

    localparam int unsigned     PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_COUNT = DEPTH[PTR_W:0];

    store_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/rv32_data_bus_bridge.sv
// Data-port bridge: posts stores into a FIFO drained on a valid/ready bus,
// orders loads behind pending stores, and stalls the core while a request waits.
module rv32_data_bus_bridge
    import rv32_data_bus_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  core_write_enable_i,
    input  logic        core_read_i,
    input  logic [31:0] core_address_i,
    input  logic [31:0] core_write_data_i,
    output logic [31:0] core_read_data_o,
    output logic        core_stall_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_write_o,
    output logic [3:0]  bus_strobe_o,
    output logic [31:0] bus_address_o,
    output logic [31:0] bus_write_data_o,
    input  logic        bus_read_valid_i,
    input  logic [31:0] bus_read_data_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    bridge_state_t state;
    logic [31:0]   read_data_q;
    logic          is_store;
    logic          is_load;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drain_valid;
    logic          last_pop;
    logic [CNT_W-1:0] fifo_count;
    store_entry_t  head;
    store_entry_t  new_entry;

    // A nonzero strobe makes the request a store regardless of core_read_i.
    assign is_store    = |core_write_enable_i;
    assign is_load     = core_read_i && !is_store;
    assign drain_valid = ((state == IDLE) || (state == DRAIN)) && !fifo_empty;
    assign push        = (state == IDLE) && is_store && !fifo_full;
    assign pop         = drain_valid && bus_ready_i;
    assign last_pop    = pop && (fifo_count == CNT_W'(1));
    assign new_entry   = '{addr: core_address_i, strobe: core_write_enable_i, data: core_write_data_i};

    assign core_read_data_o = read_data_q;

    rv32_store_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_store_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .pop        (pop),
        .push_entry (new_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (head)
    );

    // Stall and bus request decode from state, FIFO head and core inputs.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        core_stall_o     = 1'b0;
        bus_valid_o      = 1'b0;
        bus_write_o      = 1'b0;
        bus_strobe_o     = '0;
        bus_address_o    = '0;
        bus_write_data_o = '0;
        if (!rst_i) begin
            case (state)
                IDLE:                      core_stall_o = is_load || (is_store && fifo_full);
                DRAIN, READ_REQ, READ_WAIT: core_stall_o = 1'b1;
                default:                   core_stall_o = 1'b0;
            endcase
        end
        if (drain_valid) begin
            bus_valid_o      = 1'b1;
            bus_write_o      = 1'b1;
            bus_strobe_o     = head.strobe;
            bus_address_o    = word_align(head.addr);
            bus_write_data_o = head.data;
        end else if (state == READ_REQ) begin
            bus_valid_o   = 1'b1;
            bus_strobe_o  = FULL_STROBE;
            bus_address_o = word_align(core_address_i);
        end
    end

    // Load sequencing: drain posted stores, issue the read, capture data, retire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            read_data_q <= '0;
        end else begin
            case (state)
                IDLE:      if (is_load) state <= fifo_empty ? READ_REQ : DRAIN;
                DRAIN:     if (fifo_empty || last_pop) state <= READ_REQ;
                READ_REQ:  if (bus_ready_i) state <= READ_WAIT;
                READ_WAIT: if (bus_read_valid_i) begin
                               read_data_q <= bus_read_data_i;
                               state       <= DONE;
                           end
                DONE:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
